// File: rtl/sd_sector_bridge.sv
// Two-drive sector request arbiter in front of the SD wrapper, owning one 512-byte sector buffer.
// Optional watchdog per transfer enabled by defining SD_BRIDGE_TIMEOUT_EN.
module sd_sector_bridge #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000,
  parameter logic        RR_START       = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  drv_rd,
  input  logic [1:0]  drv_wr,
  input  logic [31:0] drv_lba0,
  input  logic [31:0] drv_lba1,
  output logic [1:0]  drv_ack,
  output logic        drv_err,
  output logic [1:0]  drv_grant,
  input  logic [8:0]  buf_addr,
  input  logic        buf_we,
  input  logic [7:0]  buf_din,
  output logic [7:0]  buf_dout,
  input  logic [1:0]  image_mounted,
  output logic [1:0]  rstart,
  output logic [1:0]  wstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte,
  output logic [7:0]  inbyte
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rd_q, rd_d;
  logic        contest_q, contest_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] rsector_q, rsector_d;
  logic [1:0]  rstart_q, rstart_d;
  logic [1:0]  wstart_q, wstart_d;
  logic [1:0]  ack_q, ack_d;
  logic        err_q, err_d;
  logic [7:0]  buf_dout_q;
  logic [7:0]  mem [512];

  logic [1:0]  cand;
  logic        sel;
  logic [1:0]  sel_oh, own_oh;
  logic        xfer_active;
  logic        tmo;
  logic        unused_rbusy;

  assign unused_rbusy = rbusy;
  assign cand        = drv_rd | drv_wr;
  assign sel         = (cand == 2'b11) ? ptr_q : cand[1];
  assign sel_oh      = sel ? 2'b10 : 2'b01;
  assign own_oh      = owner_q ? 2'b10 : 2'b01;
  assign xfer_active = (state_q == S_ISSUE) || (state_q == S_WAIT);

`ifdef SD_BRIDGE_TIMEOUT_EN
  logic [23:0] cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_d == S_ISSUE && state_q != S_ISSUE) begin
      cnt_q <= '0;
    end else if (xfer_active) begin
      cnt_q <= cnt_q + 24'd1;
    end
  end
  assign tmo = xfer_active && (cnt_q == TIMEOUT_CYCLES - 24'd1);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rd_d      = rd_q;
    contest_d = contest_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    rsector_d = rsector_q;
    rstart_d  = rstart_q;
    wstart_d  = wstart_q;
    ack_d     = 2'b00;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|cand) begin
          owner_d   = sel;
          contest_d = &cand;
          grant_d   = sel_oh;
          rsector_d = sel ? drv_lba1 : drv_lba0;
          rd_d      = drv_rd[sel];
          if (!image_mounted[sel]) begin
            // rd_q cleared so an errored read releases the buffer with the ack
            rd_d    = 1'b0;
            state_d = S_DONE;
            ack_d   = sel_oh;
            err_d   = 1'b1;
          end else if (drv_rd[sel]) begin
            state_d  = S_ISSUE;
            rstart_d = sel_oh;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (buf_we && buf_addr == 9'h1FF) begin
          state_d  = S_ISSUE;
          wstart_d = own_oh;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (rdone || tmo) begin
          state_d  = S_DONE;
          rstart_d = 2'b00;
          wstart_d = 2'b00;
          ack_d    = own_oh;
          err_d    = !rdone;
          if (!rdone) rd_d = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        if (!(rd_q && drv_rd[owner_q])) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          // Pointer moves only after a contested grant, so the loser of a tie wins the next tie
          if (contest_q) ptr_d = ~owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      rd_q       <= 1'b0;
      contest_q  <= 1'b0;
      ptr_q      <= RR_START;
      grant_q    <= 2'b00;
      rsector_q  <= '0;
      rstart_q   <= 2'b00;
      wstart_q   <= 2'b00;
      ack_q      <= 2'b00;
      err_q      <= 1'b0;
      buf_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rd_q       <= rd_d;
      contest_q  <= contest_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      rsector_q  <= rsector_d;
      rstart_q   <= rstart_d;
      wstart_q   <= wstart_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      buf_dout_q <= mem[buf_addr];
    end
  end

  // Wrapper read data takes the single write port ahead of the drive
  always_ff @(posedge clk) begin
    if (outen && rd_q && xfer_active) begin
      mem[outaddr] <= outbyte;
    end else if (buf_we && (grant_q != 2'b00) &&
                 (state_q == S_FILL || state_q == S_DONE)) begin
      mem[buf_addr] <= buf_din;
    end
  end

  assign inbyte    = mem[outaddr];
  assign buf_dout  = buf_dout_q;
  assign drv_ack   = ack_q;
  assign drv_err   = err_q;
  assign drv_grant = grant_q;
  assign rstart    = rstart_q;
  assign wstart    = wstart_q;
  assign rsector   = rsector_q;

endmodule

// File: tb/tb_sd_sector_bridge.sv
// Scoreboard bench for sd_sector_bridge: expected starts/acks queued by stimulus, popped by monitors.
module tb_sd_sector_bridge;

`ifdef SD_BRIDGE_TIMEOUT_EN
  localparam logic [23:0] TB_TMO = 24'd100;
`else
  localparam logic [23:0] TB_TMO = 24'd12000000;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  drv_rd, drv_wr, drv_ack, drv_grant, image_mounted, rstart, wstart;
  logic [31:0] drv_lba0, drv_lba1, rsector;
  logic        drv_err, buf_we, rbusy, rdone, outen;
  logic [8:0]  buf_addr, outaddr;
  logic [7:0]  buf_din, buf_dout, outbyte, inbyte;

  sd_sector_bridge #(.TIMEOUT_CYCLES(TB_TMO), .RR_START(1'b0)) dut (
    .clk(clk), .rstn(rstn), .drv_rd(drv_rd), .drv_wr(drv_wr),
    .drv_lba0(drv_lba0), .drv_lba1(drv_lba1), .drv_ack(drv_ack), .drv_err(drv_err),
    .drv_grant(drv_grant), .buf_addr(buf_addr), .buf_we(buf_we), .buf_din(buf_din),
    .buf_dout(buf_dout), .image_mounted(image_mounted), .rstart(rstart), .wstart(wstart),
    .rsector(rsector), .rbusy(rbusy), .rdone(rdone), .outen(outen), .outaddr(outaddr),
    .outbyte(outbyte), .inbyte(inbyte)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] start_q[$];
  logic [2:0]  ack_q[$];
  logic [3:0]  st_prev = 4'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (drv_ack != 2'b00) begin
        if (ack_q.size() == 0) chk("ack_unexpected", {drv_ack, drv_err}, 0);
        else chk("ack_err", {drv_ack, drv_err}, ack_q.pop_front());
      end
      if ({rstart, wstart} != 4'h0 && st_prev == 4'h0) begin
        if (start_q.size() == 0) chk("start_unexpected", {rstart, wstart}, 0);
        else chk("start_sector", {rstart, wstart, rsector}, start_q.pop_front());
      end
      st_prev = {rstart, wstart};
    end else begin
      st_prev = 4'h0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while ((rstart | wstart) == 2'b00 && n < 2000) begin tick(); n++; end
    chk(nm, |{rstart, wstart}, 1);
  endtask

  task automatic wait_ack(input string nm);
    int n = 0;
    while (drv_ack == 2'b00 && n < 2000) begin tick(); n++; end
    chk(nm, |drv_ack, 1);
  endtask

  task automatic pulse_rdone();
    rdone = 1'b1;
    tick();
    rdone = 1'b0;
  endtask

  task automatic serve_one_read();
    wait_start("rr_start_seen");
    pulse_rdone();
    wait_ack("rr_ack_seen");
    if (drv_ack[0]) drv_rd[0] = 1'b0;
    else drv_rd[1] = 1'b0;
    tick();
  endtask

  initial begin
    rstn = 1'b0; drv_rd = 0; drv_wr = 0; drv_lba0 = 0; drv_lba1 = 0;
    buf_addr = 0; buf_we = 0; buf_din = 0; image_mounted = 2'b11;
    rbusy = 0; rdone = 0; outen = 0; outaddr = 0; outbyte = 0;
    #3;
    chk("reset_starts", {rstart, wstart}, 0);
    chk("reset_rsector", rsector, 0);
    chk("reset_ack_err_grant", {drv_ack, drv_err, drv_grant}, 0);
    chk("reset_buf_dout", buf_dout, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    // Simultaneous pairs: 0 then 1, then 1 then 0
    drv_lba0 = 32'h200; drv_lba1 = 32'h300;
    start_q.push_back({4'b0100, 32'h200}); ack_q.push_back(3'b010);
    start_q.push_back({4'b1000, 32'h300}); ack_q.push_back(3'b100);
    drv_rd = 2'b11;
    tick();
    serve_one_read();
    serve_one_read();
    start_q.push_back({4'b1000, 32'h300}); ack_q.push_back(3'b100);
    start_q.push_back({4'b0100, 32'h200}); ack_q.push_back(3'b010);
    drv_rd = 2'b11;
    tick();
    serve_one_read();
    serve_one_read();

    // Drive 0 read with streamed data i^0x5A
    drv_lba0 = 32'h123;
    start_q.push_back({4'b0100, 32'h123}); ack_q.push_back(3'b010);
    drv_rd = 2'b01;
    tick();
    wait_start("rd_start_seen");
    for (int i = 0; i < 512; i++) begin
      outen = 1'b1; outaddr = i[8:0]; outbyte = i[7:0] ^ 8'h5A;
      tick();
    end
    outen = 1'b0;
    pulse_rdone();
    wait_ack("rd_ack_seen");
    chk("rd_grant_held", drv_grant, 2'b01);
    buf_addr = 9'd7;
    tick();
    chk("rd_buf_addr7", buf_dout, 8'h5D);
    buf_addr = 9'h1FF;
    tick();
    chk("rd_buf_addr511", buf_dout, 8'hA5);
    drv_rd = 2'b00;
    tick(); tick();
    chk("rd_grant_released", drv_grant, 2'b00);
    buf_we = 1'b1; buf_addr = 9'd7; buf_din = 8'hEE;
    tick();
    buf_we = 1'b0;
    tick();
    chk("idle_write_ignored", buf_dout, 8'h5D);

    // Drive 1 write, buffer filled with i[7:0]
    drv_lba1 = 32'h10;
    start_q.push_back({4'b0010, 32'h10}); ack_q.push_back(3'b100);
    drv_wr = 2'b10;
    tick();
    chk("wr_grant", drv_grant, 2'b10);
    for (int i = 0; i < 512; i++) begin
      buf_we = 1'b1; buf_addr = i[8:0]; buf_din = i[7:0];
      if (i == 256) chk("fill_no_start", {rstart, wstart}, 0);
      tick();
    end
    buf_we = 1'b0;
    wait_start("wr_start_seen");
    outaddr = 9'h1FF; #1; chk("inbyte_1ff", inbyte, 8'hFF);
    outaddr = 9'h000; #1; chk("inbyte_000", inbyte, 8'h00);
    outaddr = 9'h0AB; #1; chk("inbyte_0ab", inbyte, 8'hAB);
    outaddr = 9'h100; #1; chk("inbyte_100", inbyte, 8'h00);
    tick();
    pulse_rdone();
    wait_ack("wr_ack_seen");
    drv_wr = 2'b00;
    tick(); tick();
    chk("wr_grant_released", drv_grant, 2'b00);

    // Unmounted drive 1: error ack without touching the wrapper
    image_mounted = 2'b01;
    ack_q.push_back(3'b101);
    drv_rd = 2'b10;
    tick();
    begin
      int found = 0;
      for (int i = 0; i < 3; i++) begin
        if (drv_ack != 2'b00) begin found = 1; break; end
        tick();
      end
      chk("unmounted_ack_within_3", found, 1);
    end
    drv_rd = 2'b00;
    tick(); tick();
    chk("unmounted_grant_released", drv_grant, 2'b00);
    image_mounted = 2'b11;

    // Reset while waiting on the wrapper, then a normal request
    drv_lba0 = 32'h55;
    start_q.push_back({4'b0100, 32'h55});
    drv_rd = 2'b01;
    tick();
    wait_start("rst_start_seen");
    tick(); tick();
    chk("wait_rstart_held", rstart, 2'b01);
    rstn = 1'b0;
    #1;
    chk("rst_rstart_cleared", rstart, 2'b00);
    chk("rst_grant_cleared", drv_grant, 2'b00);
    drv_rd = 2'b00;
    tick(); tick();
    rstn = 1'b1;
    tick();
    drv_lba1 = 32'h77;
    start_q.push_back({4'b1000, 32'h77}); ack_q.push_back(3'b100);
    drv_rd = 2'b10;
    tick();
    wait_start("post_rst_start_seen");
    pulse_rdone();
    wait_ack("post_rst_ack_seen");
    drv_rd = 2'b00;
    tick(); tick();

`ifdef SD_BRIDGE_TIMEOUT_EN
    drv_lba0 = 32'h99;
    start_q.push_back({4'b0100, 32'h99}); ack_q.push_back(3'b011);
    drv_rd = 2'b01;
    tick();
    wait_start("tmo_start_seen");
    begin
      int n = 0;
      while (rstart != 2'b00 && n < 300) begin tick(); n++; end
      chk("tmo_start_cycles", n, 100);
    end
    wait_ack("tmo_ack_seen");
    drv_rd = 2'b00;
    tick();
    pulse_rdone();
    for (int i = 0; i < 3; i++) begin
      chk("tmo_late_rdone_no_ack", drv_ack, 2'b00);
      tick();
    end
`endif

    tick(); tick();
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("start_queue_drained", start_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL global_timeout: bench did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
